trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/ceres_param.sv | 24 ++
 rtl/trap_ctrl_if.sv | 47 ++++
 rtl/trap_prio_sel.sv | 78 +++++++
 rtl/trap_ctrl.sv | 148 ++++++++++++++
 tb/tb_trap_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ceres_param.sv
// Shared parameters for the trap controller: data width, FSM state encoding and trap cause codes.
// Optional CERES_HW_BREAKPOINT_EN (used in trap_prio_sel) enables the hardware breakpoint comparator.
package ceres_param;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRAIN  = 2'd1,
      ENTER  = 2'd2,
      RETURN = 2'd3
   } trap_state_e;

   // Interrupt codes go into cause[XLEN-2:0] with cause[XLEN-1] set.
   localparam int unsigned CODE_MSI = 3;
   localparam int unsigned CODE_MTI = 7;
   localparam int unsigned CODE_MEI = 11;
   localparam int unsigned CAUSE_BREAKPOINT = 3;

   localparam int unsigned MIE_BIT_MSI = 3;
   localparam int unsigned MIE_BIT_MTI = 7;
   localparam int unsigned MIE_BIT_MEI = 11;

endpackage

// File: rtl/trap_ctrl_if.sv
// Pipeline/CSR-side signal bundle of trap_ctrl; the slave modport is the controller's view.
interface trap_ctrl_if #(parameter int XLEN = ceres_param::XLEN);

   logic            stall_i;
   logic            exc_valid_i;
   logic [XLEN-1:0] exc_cause_i;
   logic [XLEN-1:0] exc_pc_i;
   logic [XLEN-1:0] exc_tval_i;
   logic            instr_valid_i;
   logic [XLEN-1:0] instr_pc_i;
   logic            mret_i;
   logic            irq_sw_i;
   logic            irq_timer_i;
   logic            irq_ext_i;
   logic            mstatus_mie_i;
   logic [XLEN-1:0] mie_i;
   logic [XLEN-1:0] mtvec_i;
   logic [XLEN-1:0] mepc_i;
   logic [XLEN-1:0] tdata1_i;
   logic [XLEN-1:0] tdata2_i;

   logic            trap_active_o;
   logic [XLEN-1:0] trap_cause_o;
   logic [XLEN-1:0] trap_mepc_o;
   logic [XLEN-1:0] trap_tval_o;
   logic            redirect_valid_o;
   logic [XLEN-1:0] redirect_pc_o;
   logic            flush_o;
   logic            busy_o;

   modport master (
      output stall_i, exc_valid_i, exc_cause_i, exc_pc_i, exc_tval_i,
             instr_valid_i, instr_pc_i, mret_i, irq_sw_i, irq_timer_i, irq_ext_i,
             mstatus_mie_i, mie_i, mtvec_i, mepc_i, tdata1_i, tdata2_i,
      input  trap_active_o, trap_cause_o, trap_mepc_o, trap_tval_o,
             redirect_valid_o, redirect_pc_o, flush_o, busy_o
   );

   modport slave (
      input  stall_i, exc_valid_i, exc_cause_i, exc_pc_i, exc_tval_i,
             instr_valid_i, instr_pc_i, mret_i, irq_sw_i, irq_timer_i, irq_ext_i,
             mstatus_mie_i, mie_i, mtvec_i, mepc_i, tdata1_i, tdata2_i,
      output trap_active_o, trap_cause_o, trap_mepc_o, trap_tval_o,
             redirect_valid_o, redirect_pc_o, flush_o, busy_o
   );

endinterface

// File: rtl/trap_prio_sel.sv
// Combinational trap event selection: exception > breakpoint > MEI > MSI > MTI.
// Breakpoint comparator exists only when CERES_HW_BREAKPOINT_EN is defined.
module trap_prio_sel
   import ceres_param::*;
#(
   parameter int XLEN = ceres_param::XLEN
) (
   input  logic            exc_valid,
   input  logic [XLEN-1:0] exc_cause,
   input  logic [XLEN-1:0] exc_pc,
   input  logic [XLEN-1:0] exc_tval,
   input  logic            instr_valid,
   input  logic [XLEN-1:0] instr_pc,
   input  logic            irq_sw,
   input  logic            irq_timer,
   input  logic            irq_ext,
   input  logic            mstatus_mie,
   input  logic [XLEN-1:0] mie,
   input  logic [XLEN-1:0] tdata1,
   input  logic [XLEN-1:0] tdata2,
   output logic            valid,
   output logic [XLEN-1:0] cause,
   output logic [XLEN-1:0] mepc,
   output logic [XLEN-1:0] tval
);

   logic irq_en;
   logic mei;
   logic msi;
   logic mti;
   logic bkpt;
   logic unused_mie;

   assign irq_en     = mstatus_mie & instr_valid;
   assign mei        = irq_en & irq_ext   & mie[MIE_BIT_MEI];
   assign msi        = irq_en & irq_sw    & mie[MIE_BIT_MSI];
   assign mti        = irq_en & irq_timer & mie[MIE_BIT_MTI];
   assign unused_mie = ^mie;

`ifdef CERES_HW_BREAKPOINT_EN
   logic unused_tdata1;

   // Address-match execute trigger, M-mode only.
   assign bkpt = (tdata1[31:28] == 4'd2) & tdata1[6] & tdata1[2] & instr_valid
               & (instr_pc == tdata2);
   assign unused_tdata1 = ^tdata1;
`else
   logic unused_tdata;

   assign bkpt         = 1'b0;
   assign unused_tdata = ^{tdata1, tdata2};
`endif

   always_comb begin
      valid = 1'b1;
      cause = '0;
      mepc  = instr_pc;
      tval  = '0;
      if (exc_valid) begin
         cause = exc_cause;
         mepc  = exc_pc;
         tval  = exc_tval;
      end else if (bkpt) begin
         cause = XLEN'(CAUSE_BREAKPOINT);
         tval  = instr_pc;
      end else if (mei) begin
         cause = {1'b1, (XLEN-1)'(CODE_MEI)};
      end else if (msi) begin
         cause = {1'b1, (XLEN-1)'(CODE_MSI)};
      end else if (mti) begin
         cause = {1'b1, (XLEN-1)'(CODE_MTI)};
      end else begin
         valid = 1'b0;
         mepc  = '0;
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: captures a trap or MRET, waits out pipeline stalls,
// then issues a one-cycle CSR commit / fetch redirect / flush. Optional macro: CERES_HW_BREAKPOINT_EN.
module trap_ctrl
   import ceres_param::*;
#(
   parameter int XLEN = ceres_param::XLEN
) (
   input logic         clk_i,
   input logic         rst_ni,
   trap_ctrl_if.slave  bus
);

   trap_state_e     state;
   logic            sel_valid;
   logic [XLEN-1:0] sel_cause;
   logic [XLEN-1:0] sel_mepc;
   logic [XLEN-1:0] sel_tval;
   logic [XLEN-1:0] cause_q;
   logic [XLEN-1:0] mepc_q;
   logic [XLEN-1:0] tval_q;
   logic            ret_q;

   logic            trap_active_q;
   logic [XLEN-1:0] trap_cause_q;
   logic [XLEN-1:0] trap_mepc_q;
   logic [XLEN-1:0] trap_tval_q;
   logic            redirect_valid_q;
   logic [XLEN-1:0] redirect_pc_q;
   logic            flush_q;

   logic            take_ret;
   logic            go_enter;
   logic            go_return;
   logic [XLEN-1:0] nxt_cause;
   logic [XLEN-1:0] nxt_mepc;
   logic [XLEN-1:0] nxt_tval;

   trap_prio_sel #(.XLEN(XLEN)) u_prio (
      .exc_valid   (bus.exc_valid_i),
      .exc_cause   (bus.exc_cause_i),
      .exc_pc      (bus.exc_pc_i),
      .exc_tval    (bus.exc_tval_i),
      .instr_valid (bus.instr_valid_i),
      .instr_pc    (bus.instr_pc_i),
      .irq_sw      (bus.irq_sw_i),
      .irq_timer   (bus.irq_timer_i),
      .irq_ext     (bus.irq_ext_i),
      .mstatus_mie (bus.mstatus_mie_i),
      .mie         (bus.mie_i),
      .tdata1      (bus.tdata1_i),
      .tdata2      (bus.tdata2_i),
      .valid       (sel_valid),
      .cause       (sel_cause),
      .mepc        (sel_mepc),
      .tval        (sel_tval)
   );

   function automatic logic [XLEN-1:0] target_pc(input logic [XLEN-1:0] mtvec,
                                                 input logic [XLEN-1:0] cause);
      logic [XLEN-1:0] base;
      base = {mtvec[XLEN-1:2], 2'b00};
      if (mtvec[1:0] == 2'b01 && cause[XLEN-1])
         return base + {cause[XLEN-3:0], 2'b00};
      return base;
   endfunction

   // MRET loses to any qualified event in the same cycle.
   assign take_ret  = bus.mret_i & bus.instr_valid_i & ~sel_valid;
   assign go_enter  = ~bus.stall_i & ((state == IDLE && sel_valid) || (state == DRAIN && !ret_q));
   assign go_return = ~bus.stall_i & ((state == IDLE && take_ret)  || (state == DRAIN && ret_q));
   assign nxt_cause = (state == IDLE) ? sel_cause : cause_q;
   assign nxt_mepc  = (state == IDLE) ? sel_mepc  : mepc_q;
   assign nxt_tval  = (state == IDLE) ? sel_tval  : tval_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state            <= IDLE;
         cause_q          <= '0;
         mepc_q           <= '0;
         tval_q           <= '0;
         ret_q            <= 1'b0;
         trap_active_q    <= 1'b0;
         trap_cause_q     <= '0;
         trap_mepc_q      <= '0;
         trap_tval_q      <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         flush_q          <= 1'b0;
      end else begin
         // NOTE: pulse outputs default low every cycle; the later non-blocking
         // assignments below override them only on the cycle entering ENTER/RETURN.
         trap_active_q    <= 1'b0;
         trap_cause_q     <= '0;
         trap_mepc_q      <= '0;
         trap_tval_q      <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         flush_q          <= 1'b0;

         unique case (state)
            IDLE: begin
               if (sel_valid) begin
                  cause_q <= sel_cause;
                  mepc_q  <= sel_mepc;
                  tval_q  <= sel_tval;
                  ret_q   <= 1'b0;
                  state   <= bus.stall_i ? DRAIN : ENTER;
               end else if (take_ret) begin
                  ret_q <= 1'b1;
                  state <= bus.stall_i ? DRAIN : RETURN;
               end
            end
            DRAIN: begin
               if (!bus.stall_i)
                  state <= ret_q ? RETURN : ENTER;
            end
            ENTER:   state <= IDLE;
            RETURN:  state <= IDLE;
            default: state <= IDLE;
         endcase

         if (go_enter) begin
            trap_active_q    <= 1'b1;
            trap_cause_q     <= nxt_cause;
            trap_mepc_q      <= nxt_mepc;
            trap_tval_q      <= nxt_tval;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= target_pc(bus.mtvec_i, nxt_cause);
            flush_q          <= 1'b1;
         end
         if (go_return) begin
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= bus.mepc_i;
            flush_q          <= 1'b1;
         end
      end
   end

   assign bus.trap_active_o    = trap_active_q;
   assign bus.trap_cause_o     = trap_cause_q;
   assign bus.trap_mepc_o      = trap_mepc_q;
   assign bus.trap_tval_o      = trap_tval_q;
   assign bus.redirect_valid_o = redirect_valid_q;
   assign bus.redirect_pc_o    = redirect_pc_q;
   assign bus.flush_o          = flush_q;
   assign bus.busy_o           = (state != IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl; breakpoint expectations follow CERES_HW_BREAKPOINT_EN.
module tb_trap_ctrl;

   localparam int XLEN = 32;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   trap_ctrl_if #(.XLEN(XLEN)) bus ();

   trap_ctrl #(.XLEN(XLEN)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.stall_i       = 1'b0;
      bus.exc_valid_i   = 1'b0;
      bus.exc_cause_i   = '0;
      bus.exc_pc_i      = '0;
      bus.exc_tval_i    = '0;
      bus.instr_valid_i = 1'b0;
      bus.instr_pc_i    = '0;
      bus.mret_i        = 1'b0;
      bus.irq_sw_i      = 1'b0;
      bus.irq_timer_i   = 1'b0;
      bus.irq_ext_i     = 1'b0;
      bus.mstatus_mie_i = 1'b0;
      bus.mie_i         = '0;
      bus.mtvec_i       = '0;
      bus.mepc_i        = '0;
      bus.tdata1_i      = '0;
      bus.tdata2_i      = '0;
   endtask

   task automatic expect_quiet(input string tag);
      check({tag, "_active"},   bus.trap_active_o,    32'd0);
      check({tag, "_redir"},    bus.redirect_valid_o, 32'd0);
      check({tag, "_flush"},    bus.flush_o,          32'd0);
      check({tag, "_cause"},    bus.trap_cause_o,     32'd0);
      check({tag, "_redir_pc"}, bus.redirect_pc_o,    32'd0);
   endtask

   task automatic expect_trap(input string tag, input logic [31:0] cause, input logic [31:0] mepc,
                              input logic [31:0] tval, input logic [31:0] pc);
      check({tag, "_active"},   bus.trap_active_o,    32'd1);
      check({tag, "_redir"},    bus.redirect_valid_o, 32'd1);
      check({tag, "_flush"},    bus.flush_o,          32'd1);
      check({tag, "_cause"},    bus.trap_cause_o,     cause);
      check({tag, "_mepc"},     bus.trap_mepc_o,      mepc);
      check({tag, "_tval"},     bus.trap_tval_o,      tval);
      check({tag, "_redir_pc"}, bus.redirect_pc_o,    pc);
      check({tag, "_busy"},     bus.busy_o,           32'd1);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      clear_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      expect_quiet("reset");
      check("reset_busy", bus.busy_o, 32'd0);
      rst_n = 1'b1;
      tick();
      expect_quiet("post_reset");

      // Synchronous exception, non-vectored mtvec
      bus.exc_valid_i = 1'b1;
      bus.exc_cause_i = 32'd2;
      bus.exc_pc_i    = 32'h100;
      bus.exc_tval_i  = 32'hDEAD;
      bus.mtvec_i     = 32'h8000_0000;
      tick();
      bus.exc_valid_i = 1'b0;
      expect_trap("exc", 32'd2, 32'h100, 32'hDEAD, 32'h8000_0000);
      tick();
      expect_quiet("exc_after");
      check("exc_after_busy", bus.busy_o, 32'd0);

      // Vectored timer interrupt
      bus.mie_i         = 32'h80;
      bus.mstatus_mie_i = 1'b1;
      bus.irq_timer_i   = 1'b1;
      bus.instr_valid_i = 1'b1;
      bus.instr_pc_i    = 32'h200;
      bus.mtvec_i       = 32'h8000_0001;
      tick();
      bus.irq_timer_i = 1'b0;
      expect_trap("mti", 32'h8000_0007, 32'h200, 32'h0, 32'h8000_001C);
      tick();
      expect_quiet("mti_after");

      // Interrupt must not qualify without a valid instruction or with MIE clear
      bus.irq_timer_i   = 1'b1;
      bus.instr_valid_i = 1'b0;
      tick();
      check("irq_no_instr_busy", bus.busy_o, 32'd0);
      bus.instr_valid_i = 1'b1;
      bus.mstatus_mie_i = 1'b0;
      tick();
      check("irq_mie_off_busy", bus.busy_o, 32'd0);
      bus.irq_timer_i   = 1'b0;
      bus.mstatus_mie_i = 1'b1;

      // MSI beats MTI, vectored offset 4*3
      bus.mie_i       = 32'h88;
      bus.irq_sw_i    = 1'b1;
      bus.irq_timer_i = 1'b1;
      bus.instr_pc_i  = 32'h240;
      tick();
      bus.irq_sw_i    = 1'b0;
      bus.irq_timer_i = 1'b0;
      expect_trap("msi", 32'h8000_0003, 32'h240, 32'h0, 32'h8000_000C);
      tick();

      // Exception beats MEI/MTI; the still-pending MEI is taken after ENTER
      bus.mie_i       = 32'h880;
      bus.irq_ext_i   = 1'b1;
      bus.irq_timer_i = 1'b1;
      bus.exc_valid_i = 1'b1;
      bus.exc_cause_i = 32'd11;
      bus.exc_pc_i    = 32'h300;
      bus.exc_tval_i  = 32'h0;
      bus.instr_pc_i  = 32'h304;
      tick();
      bus.exc_valid_i = 1'b0;
      expect_trap("prio_exc", 32'd11, 32'h300, 32'h0, 32'h8000_0000);
      tick();
      check("prio_gap_active", bus.trap_active_o, 32'd0);
      check("prio_gap_busy", bus.busy_o, 32'd0);
      tick();
      expect_trap("prio_mei", 32'h8000_000B, 32'h304, 32'h0, 32'h8000_002C);
      bus.irq_ext_i   = 1'b0;
      bus.irq_timer_i = 1'b0;
      tick();

      // Non-vectored mtvec with an interrupt goes to the base
      bus.mtvec_i   = 32'h8000_0000;
      bus.irq_ext_i = 1'b1;
      tick();
      bus.irq_ext_i = 1'b0;
      check("mei_direct_pc", bus.redirect_pc_o, 32'h8000_0000);
      tick();

      // Exception under a 3-cycle stall; a later event during DRAIN is dropped
      bus.stall_i     = 1'b1;
      bus.exc_valid_i = 1'b1;
      bus.exc_cause_i = 32'd5;
      bus.exc_pc_i    = 32'h500;
      bus.exc_tval_i  = 32'h55;
      tick();
      bus.exc_cause_i = 32'd7;
      bus.exc_pc_i    = 32'h700;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("drain%0d_busy", i), bus.busy_o, 32'd1);
         check($sformatf("drain%0d_active", i), bus.trap_active_o, 32'd0);
         if (i == 2) begin
            bus.stall_i     = 1'b0;
            bus.exc_valid_i = 1'b0;
         end
         if (i < 2) tick();
      end
      tick();
      expect_trap("drain_enter", 32'd5, 32'h500, 32'h55, 32'h8000_0000);
      tick();
      expect_quiet("drain_after");

      // MRET, immediate
      bus.mret_i = 1'b1;
      bus.mepc_i = 32'h344;
      tick();
      bus.mret_i = 1'b0;
      check("mret_redir", bus.redirect_valid_o, 32'd1);
      check("mret_pc", bus.redirect_pc_o, 32'h344);
      check("mret_flush", bus.flush_o, 32'd1);
      check("mret_active", bus.trap_active_o, 32'd0);
      tick();
      expect_quiet("mret_after");

      // MRET held off by a stall
      bus.stall_i = 1'b1;
      bus.mret_i  = 1'b1;
      tick();
      bus.mret_i  = 1'b0;
      check("mret_stall_busy", bus.busy_o, 32'd1);
      check("mret_stall_redir", bus.redirect_valid_o, 32'd0);
      bus.stall_i = 1'b0;
      tick();
      check("mret_late_pc", bus.redirect_pc_o, 32'h344);
      check("mret_late_active", bus.trap_active_o, 32'd0);
      tick();

      // Exception together with MRET: trap wins
      bus.mret_i      = 1'b1;
      bus.exc_valid_i = 1'b1;
      bus.exc_cause_i = 32'd4;
      bus.exc_pc_i    = 32'h600;
      bus.exc_tval_i  = 32'h66;
      tick();
      bus.mret_i      = 1'b0;
      bus.exc_valid_i = 1'b0;
      expect_trap("exc_mret", 32'd4, 32'h600, 32'h66, 32'h8000_0000);
      tick();

      // Reset during DRAIN
      bus.stall_i     = 1'b1;
      bus.exc_valid_i = 1'b1;
      tick();
      check("rst_drain_busy", bus.busy_o, 32'd1);
      rst_n = 1'b0;
      tick();
      expect_quiet("rst_drain");
      check("rst_drain_busy0", bus.busy_o, 32'd0);
      bus.stall_i     = 1'b0;
      bus.exc_valid_i = 1'b0;
      rst_n = 1'b1;
      tick();
      expect_quiet("rst_drain_release");
      check("rst_release_busy", bus.busy_o, 32'd0);

      // Reset during ENTER
      bus.exc_valid_i = 1'b1;
      tick();
      bus.exc_valid_i = 1'b0;
      check("rst_enter_pre", bus.trap_active_o, 32'd1);
      rst_n = 1'b0;
      tick();
      expect_quiet("rst_enter");
      check("rst_enter_busy", bus.busy_o, 32'd0);
      rst_n = 1'b1;
      tick();

      // Hardware breakpoint; bit 2 cleared must never match
      bus.mtvec_i       = 32'h8000_0001;
      bus.mie_i         = '0;
      bus.instr_valid_i = 1'b1;
      bus.instr_pc_i    = 32'h400;
      bus.tdata2_i      = 32'h400;
      bus.tdata1_i      = 32'h2000_0040;
      tick();
      check("bkpt_off_bit2", bus.busy_o, 32'd0);
      bus.tdata1_i = 32'h2000_0044;
      tick();
      bus.tdata1_i = '0;
`ifdef CERES_HW_BREAKPOINT_EN
      expect_trap("bkpt", 32'd3, 32'h400, 32'h400, 32'h8000_0000);
`else
      expect_quiet("bkpt_absent");
      check("bkpt_absent_busy", bus.busy_o, 32'd0);
`endif
      tick();
      clear_inputs();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
